// File: rtl/csel_add_pipe.sv
// csel_add_pipe: two-stage pipelined carry-select add/subtract with valid/ready flow control
module csel_add_pipe #(
   parameter int W     = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     s,
   output logic             cout,
   output logic             ovf,
   output logic [CNT_W-1:0] txn_cnt
);
   localparam int H = W / 2;
   logic [W-1:0] b_eff;
   logic         c_eff;
   logic [H:0]   lo_sum, hi0, hi1, hi_sel;
   logic         adv1, adv2;
   logic         s1_valid, s1_cmid, s1_sa, s1_sb;
   logic [H-1:0] s1_lo;
   logic [H:0]   s1_hi0, s1_hi1;
   // operand conditioning, low ripple, both high candidates, and stall/advance control
   always_comb begin
      b_eff  = sub ? ~b : b;
      c_eff  = sub ? ~cin : cin;
      lo_sum = {1'b0, a[H-1:0]} + {1'b0, b_eff[H-1:0]} + {{H{1'b0}}, c_eff};
      hi0    = {1'b0, a[W-1:H]} + {1'b0, b_eff[W-1:H]};
      hi1    = hi0 + {{H{1'b0}}, 1'b1};
      hi_sel = s1_cmid ? s1_hi1 : s1_hi0;
      adv2   = !out_valid || out_ready;
      adv1   = !s1_valid || adv2;
   end
   assign in_ready = adv1;
   // stage 1: capture low half, mid carry, both high candidates and sign bits on accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_lo    <= '0;
         s1_cmid  <= 1'b0;
         s1_hi0   <= '0;
         s1_hi1   <= '0;
         s1_sa    <= 1'b0;
         s1_sb    <= 1'b0;
      end else if (adv1) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_lo   <= lo_sum[H-1:0];
            s1_cmid <= lo_sum[H];
            s1_hi0  <= hi0;
            s1_hi1  <= hi1;
            s1_sa   <= a[W-1];
            s1_sb   <= b_eff[W-1];
         end
      end
   end
   // stage 2: mid carry selects the high candidate; result held while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         s         <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else if (adv2) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            s    <= {hi_sel[H-1:0], s1_lo};
            cout <= hi_sel[H];
            ovf  <= (s1_sa == s1_sb) && (hi_sel[H-1] != s1_sa);
         end
      end
   end
   // delivered-result counter, wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) txn_cnt <= '0;
      else if (out_valid && out_ready) txn_cnt <= txn_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
   end
endmodule

// File: tb/tb_csel_add_pipe.sv
// tb_csel_add_pipe: directed self-checking bench for csel_add_pipe
module tb_csel_add_pipe;
   logic        clk, rst_n, in_valid, out_ready, cin, sub;
   logic [31:0] a, b;
   logic        in_ready, out_valid, cout, ovf;
   logic [31:0] s;
   logic [15:0] txn_cnt;
   logic        in_ready_w, out_valid_w, cout_w, ovf_w;
   logic [31:0] s_w;
   logic [3:0]  txn_w;
   int          nvec = 0, nerr = 0;

   csel_add_pipe u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf), .txn_cnt(txn_cnt)
   );

   csel_add_pipe #(.W(32), .CNT_W(4)) u_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_w),
      .out_ready(out_ready), .s(s_w), .cout(cout_w), .ovf(ovf_w), .txn_cnt(txn_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset;
      in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
   endtask

   // drives one operand into an empty pipe and captures the result two edges later
   task automatic run1(input logic [31:0] ta, input logic [31:0] tb_, input logic tc, input logic ts,
                       output logic v0, output logic v1, output logic [31:0] rs,
                       output logic rc, output logic ro);
      a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      v0 = out_valid;
      @(posedge clk); #1;
      v1 = out_valid; rs = s; rc = cout; ro = ovf;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      do_reset();
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      nvec++; if (s !== 32'h0) begin nerr++; $display("FAIL reset_s: got %h want 0", s); end
      nvec++; if ({cout, ovf} !== 2'b00) begin nerr++; $display("FAIL reset_cout_ovf: got %b want 00", {cout, ovf}); end
      nvec++; if (txn_cnt !== 16'd0) begin nerr++; $display("FAIL reset_txn_cnt: got %0d want 0", txn_cnt); end
      nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_add;
      logic v0, v1, rc, ro;
      logic [31:0] rs;
      run1(32'd4, 32'd3, 1'b0, 1'b0, v0, v1, rs, rc, ro);
      nvec++; if ({v0, v1} !== 2'b01) begin nerr++; $display("FAIL add_latency: got v0v1=%b want 01", {v0, v1}); end
      nvec++; if (rs !== 32'd7) begin nerr++; $display("FAIL add_s: got %h want 7", rs); end
      nvec++; if ({rc, ro} !== 2'b00) begin nerr++; $display("FAIL add_cout_ovf: got %b want 00", {rc, ro}); end
      nvec++; if (txn_cnt !== 16'd1) begin nerr++; $display("FAIL add_txn_cnt: got %0d want 1", txn_cnt); end
   endtask

   task automatic test_carry;
      logic v0, v1, rc, ro;
      logic [31:0] rs;
      run1(32'h0000FFFF, 32'h1, 1'b0, 1'b0, v0, v1, rs, rc, ro);
      nvec++; if ({v1, rs, rc, ro} !== {1'b1, 32'h00010000, 2'b00}) begin nerr++; $display("FAIL carry_mid: got v=%b s=%h c=%b o=%b want 1 00010000 0 0", v1, rs, rc, ro); end
      run1(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, v0, v1, rs, rc, ro);
      nvec++; if ({v1, rs, rc, ro} !== {1'b1, 32'h0, 2'b10}) begin nerr++; $display("FAIL carry_out: got v=%b s=%h c=%b o=%b want 1 00000000 1 0", v1, rs, rc, ro); end
   endtask

   task automatic test_sub_ovf;
      logic v0, v1, rc, ro;
      logic [31:0] rs;
      run1(32'd5, 32'd7, 1'b0, 1'b1, v0, v1, rs, rc, ro);
      nvec++; if ({rs, rc, ro} !== {32'hFFFFFFFE, 2'b00}) begin nerr++; $display("FAIL sub_neg: got s=%h c=%b o=%b want FFFFFFFE 0 0", rs, rc, ro); end
      run1(32'd10, 32'd3, 1'b1, 1'b1, v0, v1, rs, rc, ro);
      nvec++; if ({rs, rc, ro} !== {32'd6, 2'b10}) begin nerr++; $display("FAIL sub_borrow: got s=%h c=%b o=%b want 00000006 1 0", rs, rc, ro); end
      run1(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, v0, v1, rs, rc, ro);
      nvec++; if ({rs, rc, ro} !== {32'h80000000, 2'b01}) begin nerr++; $display("FAIL add_ovf: got s=%h c=%b o=%b want 80000000 0 1", rs, rc, ro); end
      run1(32'h80000000, 32'h1, 1'b0, 1'b1, v0, v1, rs, rc, ro);
      nvec++; if ({rs, rc, ro} !== {32'h7FFFFFFF, 2'b11}) begin nerr++; $display("FAIL sub_ovf: got s=%h c=%b o=%b want 7FFFFFFF 1 1", rs, rc, ro); end
   endtask

   task automatic test_back_to_back;
      int na = 0, nd = 0, first_d = -1, last_d = -1;
      logic acc, del;
      logic [15:0] base;
      base = txn_cnt;
      for (int c = 0; c < 20 && nd < 5; c++) begin
         out_ready = (c >= 4);
         in_valid = (na < 5);
         a = na + 1; b = na + 1; cin = 1'b0; sub = 1'b0;
         #1;
         if (c == 2) begin
            nvec++; if ({in_ready, na[2:0]} !== {1'b0, 3'd2}) begin nerr++; $display("FAIL bp_in_ready: got in_ready=%b accepts=%0d want 0 2", in_ready, na); end
         end
         if (c == 2 || c == 3) begin
            nvec++; if ({out_valid, s} !== {1'b1, 32'd2}) begin nerr++; $display("FAIL bp_hold: cycle %0d got v=%b s=%h want 1 00000002", c, out_valid, s); end
         end
         acc = in_valid && in_ready;
         del = out_valid && out_ready;
         if (del) begin
            nvec++; if (s !== 32'(2 * (nd + 1))) begin nerr++; $display("FAIL bp_order: got %0d want %0d", s, 2 * (nd + 1)); end
            if (first_d < 0) first_d = c;
            last_d = c;
            nd++;
         end
         if (acc) na++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      nvec++; if (nd != 5) begin nerr++; $display("FAIL bp_timeout: got %0d deliveries want 5", nd); end
      nvec++; if (last_d - first_d != 4) begin nerr++; $display("FAIL bp_b2b: got span %0d want 4", last_d - first_d); end
      nvec++; if (txn_cnt !== base + 16'd5) begin nerr++; $display("FAIL bp_txn_cnt: got %0d want %0d", txn_cnt, base + 16'd5); end
   endtask

   task automatic test_reset_mid;
      logic v0, v1, rc, ro;
      logic [31:0] rs;
      out_ready = 1'b0;
      a = 32'd10; b = 32'd10; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 32'd20; b = 32'd20;
      @(posedge clk); #1;
      in_valid = 1'b0;
      nvec++; if ({out_valid, in_ready} !== 2'b10) begin nerr++; $display("FAIL mid_full: got v=%b rdy=%b want 1 0", out_valid, in_ready); end
      #2 rst_n = 1'b0;
      #1;
      nvec++; if ({out_valid, s} !== {1'b0, 32'h0}) begin nerr++; $display("FAIL mid_async: got v=%b s=%h want 0 00000000", out_valid, s); end
      nvec++; if (txn_cnt !== 16'd0) begin nerr++; $display("FAIL mid_txn_cnt: got %0d want 0", txn_cnt); end
      @(posedge clk); #1;
      rst_n = 1'b1; out_ready = 1'b1;
      #1;
      run1(32'd1, 32'd1, 1'b0, 1'b0, v0, v1, rs, rc, ro);
      nvec++; if ({v0, v1, rs} !== {2'b01, 32'd2}) begin nerr++; $display("FAIL mid_first: got v0v1=%b s=%h want 01 00000002", {v0, v1}, rs); end
   endtask

   task automatic test_wrap;
      int na = 0, nd = 0;
      do_reset();
      for (int c = 0; c < 60 && nd < 17; c++) begin
         in_valid = (na < 17);
         a = na; b = 32'd1; cin = 1'b0; sub = 1'b0;
         #1;
         if (out_valid && out_ready) nd++;
         if (in_valid && in_ready) na++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      nvec++; if (nd != 17) begin nerr++; $display("FAIL wrap_timeout: got %0d deliveries want 17", nd); end
      nvec++; if (txn_w !== 4'd1) begin nerr++; $display("FAIL wrap_cnt4: got %0d want 1", txn_w); end
      nvec++; if (txn_cnt !== 16'd17) begin nerr++; $display("FAIL wrap_cnt16: got %0d want 17", txn_cnt); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_carry();
      test_sub_ovf();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/csel_add_pipe.md
Name: csel_add_pipe

Overview:
- Pipelined 32-bit add/subtract responder. Accepts operand transactions from an upstream driver over a valid/ready handshake and returns results over a second valid/ready handshake.
- The datapath is split across 2 register stages. Stage 1 is the low-half ripple; stage 2 is the high-half carry-select, with the carry from stage 1 picking the precomputed carry-0 or carry-1 high sum.
- It is the clocked, flow-controlled counterpart of the combinational carry-select adder. It sits between operand sources and result consumers.

Parameters:
- W, 32, operand width; must be even.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand transaction present
- in_ready  output  1  block accepts operands this cycle
- a  input  W  operand A
- b  input  W  operand B
- cin  input  1  carry-in (add) or borrow-in (sub)
- sub  input  1  0: a+b+cin; 1: a-b-cin
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- s  output  W  sum/difference
- cout  output  1  carry-out (add) / not-borrow (sub)
- ovf  output  1  signed overflow
- txn_cnt  output  CNT_W  results delivered, wraps

Behaviour:
- Reset:
  - Asynchronous assert when rst_n=0.
  - out_valid=0, s=0, cout=0, ovf=0, txn_cnt=0.
  - Both stage-valid registers are cleared; in-flight data is dropped.
  - in_ready=1 as soon as reset is released.
- Operand encoding:
  - b_eff = sub ? ~b : b.
  - c_eff = sub ? ~cin : cin.
  - Result = a + b_eff + c_eff, computed modulo 2^W.
  - cout is the carry out of bit W-1.
  - ovf = (a[W-1]==b_eff[W-1]) && (s[W-1]!=a[W-1]).
- Handshakes:
  - Accept occurs when in_valid && in_ready.
  - Deliver occurs when out_valid && out_ready.
- Stage 1, registered on accept:
  - Low-half sum a[W/2-1:0]+b_eff[W/2-1:0]+c_eff, with its carry c_mid.
  - High-half candidates hi0 = a_hi+b_eff_hi+0 and hi1 = a_hi+b_eff_hi+1, each with its own carry-out.
  - Sign bits needed for ovf.
- Stage 2:
  - Selects hi1 if c_mid, else hi0, together with the matching carry.
  - Assembles s, cout, ovf and holds them in the output register.
- Flow control:
  - adv2 = !out_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1.
  - in_ready is combinational from out_ready. There is no combinational path from in_valid to in_ready.
- Latency: result is visible at out_valid exactly 2 cycles after the accepting edge when there is no backpressure.
- Throughput: 1 transaction per cycle when out_ready is held high.
- Stall:
  - While out_valid && !out_ready, s/cout/ovf hold stable.
  - Stage 1 holds its content.
  - in_ready falls once stage 1 is also full.
  - Maximum occupancy is 2 transactions. No data is lost or duplicated.
- Simultaneous deliver and accept: when the pipeline is full and out_ready=1, everything shifts one slot, a new operand is accepted, and occupancy stays at 2.
- Ordering: results leave in strict acceptance order.
- txn_cnt: increments by 1 on each deliver and wraps from 2^CNT_W-1 to 0.
- Bubbles: out_valid deasserts when stage 2 advances with stage 1 empty. s may then retain its last value.
- Reset mid-operation: pending results are discarded. After release, the first out_valid corresponds to the first post-reset accept.

Test Plan:
- Add, one transaction: a=4, b=3, cin=0, sub=0, out_ready=1 → out_valid high 2 cycles after accept; s=7, cout=0, ovf=0; txn_cnt=1.
- Carry across halves and out: a=32'h0000FFFF, b=1, cin=0 → s=32'h00010000, cout=0. Then a=32'hFFFFFFFF, b=0, cin=1 → s=0, cout=1.
- Subtract and overflow:
  - a=5, b=7, sub=1, cin=0 → s=32'hFFFFFFFE, cout=0.
  - a=32'h7FFFFFFF, b=1, sub=0 → s=32'h80000000, ovf=1.
  - a=32'h80000000, b=1, sub=1 → ovf=1.
- Backpressure: stream 5 operand pairs (i, i) for i=1..5 with out_ready=0 for 4 cycles → in_ready drops after 2 accepts and results hold stable. Release → outputs 2,4,6,8,10 in order, back-to-back; txn_cnt=5.
- Reset mid-flight: accept 2 transactions, pull rst_n low between clock edges → out_valid=0 immediately and txn_cnt=0. After release, a=1, b=1 → first result is s=2.
- Counter wrap with CNT_W=4: deliver 17 results → txn_cnt=1.
